// File: rtl/prbs_checker.sv
// Receive-side PRBS7 (x^7 + x^6 + 1) checker: self-seeds from the incoming stream,
// verifies alignment, then counts checked bits and bit errors with windowed loss of lock.
module prbs_checker #(
  parameter int LOCK_COUNT  = 16,
  parameter int WIN_LEN     = 64,
  parameter int UNLOCK_ERRS = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clear,
  input  logic             data_in,
  input  logic             data_in_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int WB_W = $clog2(WIN_LEN + 1);
  localparam int WE_W = $clog2(UNLOCK_ERRS + 1);
  localparam int MC_W = 8;

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  state_t          state;
  logic [6:0]      s;
  logic [2:0]      seed_cnt;
  logic [MC_W-1:0] match_cnt;
  logic [WB_W-1:0] win_bits;
  logic [WE_W-1:0] win_errs;

  logic            acc, p, mism;
  logic [6:0]      s_in;
  logic [WE_W-1:0] win_errs_nx;

  always_comb begin
    acc         = en & data_in_valid;
    p           = s[6] ^ s[5];
    mism        = data_in ^ p;
    s_in        = {s[5:0], data_in};
    win_errs_nx = win_errs + WE_W'(mism);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= SEED;
      s         <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      bit_count <= '0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (acc) begin
        case (state)
          SEED: begin
            s <= s_in;
            if (seed_cnt == 3'd6) begin
              seed_cnt <= '0;
              // an all-zero seed is the LFSR lock-up state, so keep seeding
              if (s_in != '0) begin
                state     <= VERIFY;
                match_cnt <= '0;
              end
            end else begin
              seed_cnt <= seed_cnt + 3'd1;
            end
          end
          VERIFY: begin
            s <= s_in;
            if (!mism) begin
              if (match_cnt == MC_W'(LOCK_COUNT - 1)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                win_bits <= '0;
                win_errs <= '0;
              end else begin
                match_cnt <= match_cnt + MC_W'(1);
              end
            end else begin
              // the mismatching bit is already in s as the first seed bit
              state    <= SEED;
              seed_cnt <= 3'd1;
            end
          end
          LOCKED: begin
            // free-run on the prediction so a flipped bit does not corrupt s
            s         <= {s[5:0], p};
            err_pulse <= mism;
            if (bit_count != '1) bit_count <= bit_count + CNT_W'(1);
            if (mism && err_count != '1) err_count <= err_count + CNT_W'(1);
            if (win_bits == WB_W'(WIN_LEN - 1)) begin
              win_bits <= '0;
              win_errs <= '0;
            end else begin
              win_bits <= win_bits + WB_W'(1);
              win_errs <= win_errs_nx;
            end
            if (win_errs_nx == WE_W'(UNLOCK_ERRS)) begin
              state    <= SEED;
              locked   <= 1'b0;
              seed_cnt <= '0;
            end
          end
          default: begin
            state  <= SEED;
            locked <= 1'b0;
          end
        endcase
      end
      if (clear) begin
        bit_count <= '0;
        err_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: scripted table of lock/error/clear steps, hand corner cases,
// and randomized traffic against a sequence-level reference model (two counter widths).
module tb_prbs_checker;
  logic        clk = 1'b0;
  logic        rstn, en, clear, data_in, data_in_valid;
  logic        locked, err_pulse, locked_s, err_pulse_s;
  logic [31:0] bc, ec;
  logic [3:0]  bc_s, ec_s;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .rstn(rstn), .en(en), .clear(clear), .data_in(data_in),
    .data_in_valid(data_in_valid), .locked(locked), .err_pulse(err_pulse),
    .bit_count(bc), .err_count(ec)
  );

  prbs_checker #(.CNT_W(4)) dut_s (
    .clk(clk), .rstn(rstn), .en(en), .clear(clear), .data_in(data_in),
    .data_in_valid(data_in_valid), .locked(locked_s), .err_pulse(err_pulse_s),
    .bit_count(bc_s), .err_count(ec_s)
  );

  int checks = 0;
  int failures = 0;
  int pulses;

  // transmit source: each new bit is the XOR of the bits sent 7 and 6 positions ago
  bit tx_q[$];
  task automatic tx_bit(output bit b);
    b = tx_q[0] ^ tx_q[1];
    void'(tx_q.pop_front());
    tx_q.push_back(b);
  endtask

  // reference model over the accepted-bit sequence
  int     m_st;          // 0 seeding, 1 verifying, 2 locked
  bit     m_h[$];        // last 7 bits of the reference sequence, oldest first
  int     m_seed, m_match, m_wb, m_we;
  longint m_bc, m_ec;
  bit     m_lk, m_pulse;

  task automatic model_reset();
    m_st = 0; m_seed = 0; m_match = 0; m_wb = 0; m_we = 0;
    m_bc = 0; m_ec = 0; m_lk = 0; m_pulse = 0;
    m_h = {};
    for (int i = 0; i < 7; i++) m_h.push_back(1'b0);
  endtask

  task automatic model_acc(input bit d);
    bit pr, nz;
    pr = m_h[0] ^ m_h[1];
    if (m_st == 0) begin
      m_h.push_back(d); void'(m_h.pop_front());
      m_seed++;
      if (m_seed == 7) begin
        m_seed = 0;
        nz = 0;
        foreach (m_h[i]) nz |= m_h[i];
        if (nz) begin m_st = 1; m_match = 0; end
      end
    end else if (m_st == 1) begin
      m_h.push_back(d); void'(m_h.pop_front());
      if (d == pr) begin
        m_match++;
        if (m_match == 16) begin m_st = 2; m_lk = 1; m_wb = 0; m_we = 0; end
      end else begin
        m_st = 0; m_seed = 1;
      end
    end else begin
      m_h.push_back(pr); void'(m_h.pop_front());
      m_bc++;
      m_wb++;
      if (d != pr) begin m_ec++; m_pulse = 1; m_we++; end
      if (m_we >= 8) begin m_st = 0; m_lk = 0; m_seed = 0; end
      if (m_wb == 64) begin m_wb = 0; m_we = 0; end
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat15(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic cyc(input bit e, input bit v, input bit d, input bit clr);
    en = e; data_in_valid = v; data_in = d; clear = clr;
    @(posedge clk); #1;
    m_pulse = 0;
    if (e && v) model_acc(d);
    if (clr) begin m_bc = 0; m_ec = 0; end
    pulses += int'(err_pulse);
    check("m_locked", locked, m_lk);
    check("m_err_pulse", err_pulse, m_pulse);
    check("m_bit_count", bc, m_bc);
    check("m_err_count", ec, m_ec);
    check("m_locked_s", locked_s, m_lk);
    check("m_err_pulse_s", err_pulse_s, m_pulse);
    check("m_bit_count_s", bc_s, sat15(m_bc));
    check("m_err_count_s", ec_s, sat15(m_ec));
  endtask

  // n valid bits from the source; the first ninv are inverted, clear rides on the first
  task automatic send(input int n, input int ninv, input bit clr);
    bit b;
    for (int i = 0; i < n; i++) begin
      tx_bit(b);
      cyc(1'b1, 1'b1, b ^ (i < ninv), clr && (i == 0));
    end
  endtask

  task automatic do_reset();
    en = 0; data_in_valid = 0; data_in = 0; clear = 0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int n; int ninv; bit clr;
    bit exp_lk; int exp_bc; int exp_ec; int exp_pulses;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit b;
    bit seen_lock;
    longint bc0, ec0;
    int burst;

    tbl[0] = '{22,   0, 1'b0, 1'b0, 0,    0, 0};
    tbl[1] = '{1,    0, 1'b0, 1'b1, 0,    0, 0};
    tbl[2] = '{1000, 0, 1'b0, 1'b1, 1000, 0, 0};
    tbl[3] = '{1,    1, 1'b0, 1'b1, 1001, 1, 1};
    tbl[4] = '{100,  0, 1'b0, 1'b1, 1101, 1, 0};
    tbl[5] = '{1,    0, 1'b1, 1'b1, 0,    0, 0};
    tbl[6] = '{8,    8, 1'b0, 1'b0, 8,    8, 8};
    tbl[7] = '{22,   0, 1'b0, 1'b0, 8,    8, 0};
    tbl[8] = '{1,    0, 1'b0, 1'b1, 8,    8, 0};

    tx_q = {};
    for (int i = 0; i < 7; i++) tx_q.push_back(1'b1);
    pulses = 0;
    do_reset();
    #1;
    check("rst_locked", locked, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_bit_count", bc, 0);
    check("rst_err_count", ec, 0);

    // scripted lock / single error / clear / loss of lock / re-lock
    for (int k = 0; k < 9; k++) begin
      pulses = 0;
      send(tbl[k].n, tbl[k].ninv, tbl[k].clr);
      check($sformatf("t%0d_locked", k), locked, tbl[k].exp_lk);
      check($sformatf("t%0d_bit_count", k), bc, tbl[k].exp_bc);
      check($sformatf("t%0d_err_count", k), ec, tbl[k].exp_ec);
      check($sformatf("t%0d_pulses", k), pulses, tbl[k].exp_pulses);
      check($sformatf("t%0d_bit_count_s", k), bc_s, sat15(tbl[k].exp_bc));
    end

    // clear together with an erroneous bit while locked
    tx_bit(b);
    cyc(1'b1, 1'b1, ~b, 1'b1);
    check("clr_err_bit_count", bc, 0);
    check("clr_err_err_count", ec, 0);
    check("clr_err_locked", locked, 1);

    // en low for 10 cycles with valid high: nothing is accepted
    send(5, 0, 1'b0);
    bc0 = bc; ec0 = ec;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    check("en_low_bit_count", bc, bc0);
    check("en_low_locked", locked, 1);
    send(20, 0, 1'b0);
    check("en_resume_bit_count", bc, bc0 + 20);
    check("en_resume_err_count", ec, ec0);

    // asynchronous reset mid-stream, then clean re-lock
    send(5, 0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("arst_locked", locked, 0);
    check("arst_bit_count", bc, 0);
    check("arst_err_count", ec, 0);
    check("arst_bit_count_s", bc_s, 0);
    check("arst_err_pulse", err_pulse, 0);
    model_reset();
    #1 rstn = 1'b1;
    send(22, 0, 1'b0);
    check("relock_early", locked, 0);
    send(1, 0, 1'b0);
    check("relock_23", locked, 1);

    // all-zero stream never locks
    do_reset();
    seen_lock = 0;
    for (int i = 0; i < 500; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      seen_lock |= locked;
    end
    check("zero_never_locked", seen_lock, 0);
    check("zero_bit_count", bc, 0);

    // randomized traffic: gaps, en-off stretches, single errors, error bursts, clears
    do_reset();
    burst = 0;
    for (int it = 0; it < 4000; it++) begin
      if ($urandom_range(0, 299) == 0) begin
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end else if ($urandom_range(0, 9) < 7) begin
        tx_bit(b);
        if (burst == 0 && $urandom_range(0, 499) == 0) burst = 10;
        if (burst > 0) begin b = ~b; burst--; end
        else if ($urandom_range(0, 49) == 0) b = ~b;
        cyc(1'b1, 1'b1, b, $urandom_range(0, 199) == 0);
      end else begin
        cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 199) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prbs_checker.md
# prbs_checker

Receive-side PRBS7 checker and bit-error counter, the reader for the transmit PRBS source. It sits after the RX gray decoder and consumes the recovered serial bit stream and its valid strobe. It self-synchronises its local LFSR to the incoming stream, declares lock, and then counts checked bits and bit errors for BER measurement. It drops lock on excessive errors and re-acquires automatically.

## Interface
- `LOCK_COUNT`, 16: consecutive correct predictions required to declare lock (1..255).
- `WIN_LEN`, 64: loss-of-lock observation window, in checked bits (2..1024).
- `UNLOCK_ERRS`, 8: errors within one window that force loss of lock (1..WIN_LEN).
- `CNT_W`, 32: width of the bit and error counters.
- `clk`, in, 1: system clock (100 MHz domain).
- `rstn`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: checker enable. When low, `data_in_valid` is ignored and all state is held.
- `clear`, in, 1: synchronous clear of `bit_count` and `err_count`. Does not affect lock state.
- `data_in`, in, 1: recovered bit from the gray decoder.
- `data_in_valid`, in, 1: `data_in` qualifier, one bit per asserted cycle.
- `locked`, out, 1: high while in the LOCKED state.
- `err_pulse`, out, 1: one-cycle pulse per mismatched bit while LOCKED.
- `bit_count`, out, CNT_W: bits checked while LOCKED. Saturating.
- `err_count`, out, CNT_W: errors while LOCKED. Saturating.

## Operation
- Polynomial: x^7 + x^6 + 1. Local state is `s[6:0]`; predicted bit `p = s[6] ^ s[5]`.
- A bit is "accepted" when `en & data_in_valid`. No state changes on non-accepted cycles.
- **SEED** (reset state):
  - On each accepted bit: `s <= {s[5:0], data_in}` and `seed_cnt++`.
  - On the 7th bit: if the new `s` is nonzero, go to VERIFY with `match_cnt = 0`.
  - If the new `s` is all-zero, stay in SEED with `seed_cnt = 0`. An all-zero stream never locks.
- **VERIFY**:
  - On each accepted bit: `s <= {s[5:0], data_in}`.
  - If `data_in == p`, increment `match_cnt`. Reaching LOCK_COUNT moves to LOCKED and clears the window counters.
  - On a mismatch, go to SEED with `seed_cnt = 1`; the mismatching bit is the first seed bit.
- **LOCKED**:
  - On each accepted bit: `s <= {s[5:0], p}`. The LFSR free-runs, so errors do not propagate.
  - `bit_count++`. On a mismatch, also `err_count++`, `err_pulse`, and `win_errs++`.
  - `win_bits++`. On the accepted bit that makes `win_bits == WIN_LEN`, reset `win_bits` and `win_errs` to 0.
  - If `win_errs` including the current bit reaches UNLOCK_ERRS, go to SEED with `seed_cnt = 0`.
  - The bit that triggers loss of lock is still counted in `bit_count` and `err_count`.
- Counters:
  - Hold at 2^CNT_W-1 once reached; no wrap.
  - `clear` takes priority over a simultaneous increment. That bit is not counted, but lock and LFSR processing of it proceed normally.
- `en` deassertion mid-stream freezes everything. Re-enable resumes from the frozen state.

## Timing
- Reset values: `locked = 0`, `err_pulse = 0`, `bit_count = 0`, `err_count = 0`. Internal state: `s = 0`, state SEED, all internal counters 0.
- All outputs are registered. Updates appear the cycle after the accepted bit's edge (1-cycle latency).
- `locked` rises the cycle after the LOCK_COUNT-th matching bit.
  - With a clean stream, that is the cycle after accepted bit 7 + LOCK_COUNT (23 with defaults).
- `locked` falls the cycle after the bit that reaches UNLOCK_ERRS. Re-lock requires at least 7 + LOCK_COUNT further accepted bits.
- `err_pulse` is high for exactly one cycle per erroneous bit. Back-to-back erroneous valid bits give a continuous high.
- Throughput: one bit per clock; `data_in_valid` may be high every cycle.
- `rstn` asserted mid-operation returns immediately to reset values, asynchronously.

## Test plan
- **Clean lock:** clean PRBS7 from seed 7'h7F, valid every cycle → `locked` rises after bit 23. After 1000 further bits, `bit_count = 1000` and `err_count = 0`.
- **Single error:** while locked, invert one bit → exactly one `err_pulse`, `err_count = 1`, `locked` stays 1. The LFSR does not lose alignment; the following 100 bits add no errors.
- **Loss of lock:** invert 8 bits within a 64-bit window → `locked` falls the cycle after the 8th error, with `err_count = 8`. Lock returns after 23 more clean bits.
- **All-zero input:** 500 all-zero bits → `locked` never asserts and the checker stays in SEED.
- **Clear and gaps:** assert `clear` together with a valid erroneous bit → counters read 0 next cycle and `locked` is unchanged. Random valid gaps and `en` low for 10 cycles → counts equal the number of accepted bits only.
- **Saturation and reset:** with `CNT_W = 4`, feed 20 locked bits → `bit_count` holds at 15. Pulse `rstn` low mid-stream → all outputs 0 immediately, then a clean re-lock after 23 bits.
